mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_dwell_cnt.sv | 31 +++
 rtl/mux_scan_sequencer.sv | 128 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // True when the given channel is the final one of a scan.
    function automatic logic last_ch(input logic [SEL_W-1:0] ch);
        return ch == SEL_W'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell timer: counts enabled cycles and flags the last cycle of each dwell
// window, then restarts from zero on its own.
module mux_scan_dwell_cnt #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && (cnt == LAST);

    // Count while enabled; wrap to zero at terminal count so dwells run back to back.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // inside the clocked block and does not appear in the sensitivity list.
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through channels 0..3, dwelling DWELL_CYCLES on
// each, samples the mux output at the end of every dwell and publishes the
// four samples as one snapshot with a single-cycle valid pulse.
// Optional build macro SCAN_CHANGE_DETECT_EN adds a 'change' output that
// flags snapshots differing from the previous one.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        mux_in,
    output logic        s0,
    output logic        s1,
    output logic [3:0]  sample_bus,
    output logic        valid,
    output logic        busy
`ifdef SCAN_CHANGE_DETECT_EN
    ,
    output logic        change
`endif
);

    scan_state_t       state, state_nxt;
    logic [SEL_W-1:0]  ch;
    logic [NUM_CH-2:0] shadow;
    logic              dwell_done;
    logic              capture_last;
    logic [NUM_CH-1:0] snapshot;

    // The channel register drives the mux select directly, so select is registered.
    assign s0 = ch[0];
    assign s1 = ch[1];

    assign capture_last = (state == SCAN) && dwell_done && last_ch(ch);
    assign snapshot     = {mux_in, shadow};

    mux_scan_dwell_cnt #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != SCAN),
        .enable (state == SCAN),
        .tc     (dwell_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (dwell_done && last_ch(ch)) state_nxt = DONE;
            DONE:    state_nxt = continuous ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            SCAN:    busy = 1'b1;
            DONE: begin
                busy  = 1'b1;
                valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Channel stepping and sample capture at the end of each dwell.
    always_ff @(posedge clk) begin
        // NOTE: the three-bit shadow is ordinary flops, not a RAM, so it is
        // reset alongside everything else to avoid leaking a stale partial scan.
        if (!rst_n) begin
            ch         <= '0;
            shadow     <= '0;
            sample_bus <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell_done) begin
                        if (last_ch(ch)) begin
                            sample_bus <= snapshot;
                            ch         <= '0;
                        end else begin
                            shadow[ch] <= mux_in;
                            ch         <= ch + 1'b1;
                        end
                    end
                end
                default: ch <= '0;
            endcase
        end
    end

`ifdef SCAN_CHANGE_DETECT_EN
    // Flag a new snapshot that differs from the one it replaces; low otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            change <= 1'b0;
        end else begin
            change <= capture_last && (snapshot != sample_bus);
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: a table of single scans plus
// directed sequences for continuous mode, start-while-busy, start held high,
// reset mid-scan and a DWELL_CYCLES=1 instance.
module tb_mux_scan_sequencer;

    typedef struct {
        logic [3:0] pattern;   // bit n = mux output when channel n selected
        logic [3:0] exp_bus;
        logic       exp_chg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, continuous;
    logic [3:0] pattern;
    logic       mux_in, s0, s1, valid, busy;
    logic [3:0] sample_bus;

    logic       start1;
    logic [3:0] pattern1;
    logic       mux_in1, s0_1, s1_1, valid1, busy1;
    logic [3:0] sample_bus1;

`ifdef SCAN_CHANGE_DETECT_EN
    logic change, change1;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs[7];

    always #5 clk = ~clk;

    // Behavioural 4:1 mux driven by the sequencer's select lines.
    assign mux_in  = pattern[{s1, s0}];
    assign mux_in1 = pattern1[{s1_1, s0_1}];

    mux_scan_sequencer #(.DWELL_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .mux_in     (mux_in),
        .s0         (s0),
        .s1         (s1),
        .sample_bus (sample_bus),
        .valid      (valid),
        .busy       (busy)
`ifdef SCAN_CHANGE_DETECT_EN
        ,
        .change     (change)
`endif
    );

    mux_scan_sequencer #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .continuous (1'b0),
        .mux_in     (mux_in1),
        .s0         (s0_1),
        .s1         (s1_1),
        .sample_bus (sample_bus1),
        .valid      (valid1),
        .busy       (busy1)
`ifdef SCAN_CHANGE_DETECT_EN
        ,
        .change     (change1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One single-shot scan with DWELL=4: per-cycle select, valid at start+17.
    task automatic run_scan(input vec_t v, input int idx);
        pattern = v.pattern;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("v%0d sel c%0d", idx, c), {30'd0, s1, s0}, (c - 1) / 4);
            check($sformatf("v%0d valid_lo c%0d", idx, c), valid, 0);
            check($sformatf("v%0d busy c%0d", idx, c), busy, 1);
            tick();
        end
        check($sformatf("v%0d valid", idx), valid, 1);
        check($sformatf("v%0d sample_bus", idx), sample_bus, v.exp_bus);
        check($sformatf("v%0d busy_done", idx), busy, 1);
`ifdef SCAN_CHANGE_DETECT_EN
        check($sformatf("v%0d change", idx), change, v.exp_chg);
`endif
        tick();
        check($sformatf("v%0d valid_after", idx), valid, 0);
        check($sformatf("v%0d busy_after", idx), busy, 0);
        check($sformatf("v%0d sel_idle", idx), {30'd0, s1, s0}, 0);
        check($sformatf("v%0d bus_hold", idx), sample_bus, v.exp_bus);
`ifdef SCAN_CHANGE_DETECT_EN
        check($sformatf("v%0d change_lo", idx), change, 0);
`endif
    endtask

    initial begin
        vecs[0] = '{4'b1101, 4'b1101, 1'b1};
        vecs[1] = '{4'b1101, 4'b1101, 1'b0};
        vecs[2] = '{4'b0001, 4'b0001, 1'b1};
        vecs[3] = '{4'b0110, 4'b0110, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1};
        vecs[5] = '{4'b1111, 4'b1111, 1'b1};
        vecs[6] = '{4'b1111, 4'b1111, 1'b0};

        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; pattern = 4'b0000;
        start1 = 1'b0; pattern1 = 4'b0000;
        tick();
        tick();

        // Reset state.
        check("rst sel", {30'd0, s1, s0}, 0);
        check("rst valid", valid, 0);
        check("rst busy", busy, 0);
        check("rst sample_bus", sample_bus, 0);
`ifdef SCAN_CHANGE_DETECT_EN
        check("rst change", change, 0);
`endif
        rst_n = 1'b1;

        // Table of single scans.
        for (int i = 0; i < 7; i++) run_scan(vecs[i], i);

        // Continuous: valid every 17 cycles; drop continuous during the second scan.
        pattern = 4'b0110; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            check($sformatf("cont valid c%0d", c), valid, (c == 17 || c == 34) ? 1 : 0);
            check($sformatf("cont busy c%0d", c), busy, (c <= 34) ? 1 : 0);
            if (c == 17 || c == 34) check($sformatf("cont bus c%0d", c), sample_bus, 4'b0110);
            if (c == 25) continuous = 1'b0;
            tick();
        end

        // Start pulses while busy are ignored: same select timeline, one valid.
        pattern = 4'b1011; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c <= 16) check($sformatf("busy_start sel c%0d", c), {30'd0, s1, s0}, (c - 1) / 4);
            check($sformatf("busy_start valid c%0d", c), valid, (c == 17) ? 1 : 0);
            if (c == 17) check("busy_start bus", sample_bus, 4'b1011);
            start = (c == 3 || c == 9) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;

        // Start held high in IDLE: one scan, back to IDLE, then a second scan.
        pattern = 4'b0101; start = 1'b1;
        tick();
        for (int c = 1; c <= 45; c++) begin
            check($sformatf("held valid c%0d", c), valid, (c == 17 || c == 35) ? 1 : 0);
            check($sformatf("held busy c%0d", c), busy, ((c <= 17) || (c >= 19 && c <= 35)) ? 1 : 0);
            if (c == 35) start = 1'b0;
            tick();
        end
        check("held bus", sample_bus, 4'b0101);

        // Reset during channel 2 abandons the scan with no snapshot.
        pattern = 4'b1110; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("mid sel ch2", {30'd0, s1, s0}, 2);
        rst_n = 1'b0;
        tick();
        check("mid rst sel", {30'd0, s1, s0}, 0);
        check("mid rst busy", busy, 0);
        check("mid rst valid", valid, 0);
        check("mid rst bus", sample_bus, 0);
        rst_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            check($sformatf("mid quiet c%0d", c), valid | busy, 0);
            tick();
        end

        // DWELL_CYCLES=1 instance: one cycle per channel, valid at start+5.
        pattern1 = 4'b1011; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("d1 sel c%0d", c), {30'd0, s1_1, s0_1}, c - 1);
            check($sformatf("d1 valid_lo c%0d", c), valid1, 0);
            tick();
        end
        check("d1 valid", valid1, 1);
        check("d1 bus", sample_bus1, 4'b1011);
        tick();
        check("d1 valid_after", valid1, 0);
        check("d1 busy_after", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
